ifetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the word-addressed, combinational-read instruction memory. It owns the fetch PC, drives the memory address every cycle and captures the returned instruction with its PC into a small prefetch FIFO. It presents the instructions to decode through a valid/ready handshake. It also accepts redirects from execute (branch/jump) and halts with a sticky error on misaligned or out-of-range fetch addresses.

---
 rtl/ifetch_if.sv | 23 ++
 rtl/ifetch_ctrl.sv | 113 +++++++++++
 tb/tb_ifetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-side bundle: instruction-memory port, execute redirect and the
// decode-facing valid/ready channel. master = fetch controller.
interface ifetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        addr_err;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, addr_err,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, addr_err,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the combinational
// instruction memory every cycle and buffers {pc, instr} in a small prefetch
// FIFO that feeds decode. Redirects flush the FIFO; bad addresses halt fetch
// with a sticky error until reset.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_SIZE   = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    ifetch_if.master bus
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    entry_t        fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          addr_err_q;

    logic full, empty, fetch_ok;
    logic do_push, do_pop, flush, set_err, load_redir;

    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // Legal only if word-aligned and inside the memory array.
    assign fetch_ok = (fetch_pc[1:0] == 2'b00) && ({2'b00, fetch_pc[31:2]} < MEM_WORDS);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-cycle FIFO/PC controls; redirect outranks push and pop.
    always_comb begin
        state_nxt  = state;
        do_pop     = !empty && bus.out_ready;
        do_push    = 1'b0;
        flush      = 1'b0;
        set_err    = 1'b0;
        load_redir = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    do_pop     = 1'b0;
                    load_redir = 1'b1;
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        state_nxt = HALT;
                        set_err   = 1'b1;
                    end
                end else if (!fetch_ok) begin
                    state_nxt = HALT;
                    set_err   = 1'b1;
                end else begin
                    do_push = !full || do_pop;
                end
            end
            HALT: ;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch PC, error flag and prefetch FIFO storage/pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            addr_err_q <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (set_err) addr_err_q <= 1'b1;
            // A misaligned redirect still lands in fetch_pc so the bad target is visible.
            if (load_redir)   fetch_pc <= bus.redirect_pc;
            else if (do_push) fetch_pc <= fetch_pc + 32'd4;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    fifo[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_rdata};
                    wr_ptr       <= wr_ptr + PW'(1);
                end
                if (do_pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            end
        end
    end

    // Outputs come straight from registers; nothing combinational from imem or redirect.
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = fifo[rd_ptr].pc;
    assign bus.out_instr = fifo[rd_ptr].instr;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, backpressure, redirects,
// misaligned and out-of-range halts, and asynchronous reset mid-stream.
module tb_ifetch_ctrl;
    localparam int MEM_SIZE   = 1024;
    localparam int FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    ifetch_if bus();

    ifetch_ctrl #(.RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory contents as a fixed function of the byte address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_rdata = instr_of(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_ins"}, bus.out_instr, instr_of(pc));
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;
        #1;
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_ins", bus.out_instr, 32'h0);
        chk("rst_err", {31'b0, bus.addr_err}, 32'd0);

        // Streaming: first entry visible in cycle 2, then one per cycle.
        reset_release();
        step();
        chk("c1_vld", {31'b0, bus.out_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            head("stream", 32'(4 * k));
        end

        // Backpressure: head 0x10 holds, FIFO fills, fetch PC stalls.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            head("bp_hold", 32'h10);
        end
        chk("bp_addr", bus.imem_addr, 32'h10 + 32'(4 * FIFO_DEPTH));
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            head("bp_rel", 32'(16 + 4 * k));
        end

        // Redirect while full with a pop offered: no stale entry.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_vld0", {31'b0, bus.out_valid}, 32'd0);
        chk("rd_addr", bus.imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            step();
            head("rd_strm", 32'(256 + 4 * k));
        end

        // Last word is delivered, the next fetch halts.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'((MEM_SIZE - 1) * 4);
        step();
        bus.redirect_valid = 1'b0;
        chk("oor_vld0", {31'b0, bus.out_valid}, 32'd0);
        step();
        head("oor_last", 32'((MEM_SIZE - 1) * 4));
        chk("oor_err0", {31'b0, bus.addr_err}, 32'd0);
        step();
        chk("oor_err", {31'b0, bus.addr_err}, 32'd1);
        chk("oor_vld", {31'b0, bus.out_valid}, 32'd0);
        // Redirect in HALT is ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        step();
        chk("halt_addr", bus.imem_addr, 32'(MEM_SIZE * 4));
        chk("halt_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("halt_err", {31'b0, bus.addr_err}, 32'd1);

        // Misaligned redirect with a full FIFO: flush plus halt.
        bus.out_ready = 1'b0;
        reset_release();
        step();
        step();
        step();
        head("mis_full", 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        chk("mis_err", {31'b0, bus.addr_err}, 32'd1);
        chk("mis_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("mis_addr", bus.imem_addr, 32'h102);
        step();
        step();
        chk("mis_vld2", {31'b0, bus.out_valid}, 32'd0);
        chk("mis_err2", {31'b0, bus.addr_err}, 32'd1);

        // Reset mid-stream, with a redirect pending, clears outputs at once.
        reset_release();
        step();
        step();
        head("mr_s0", 32'h0);
        step();
        head("mr_s1", 32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_vld", {31'b0, bus.out_valid}, 32'd0);
        chk("mr_pc", bus.out_pc, 32'h0);
        chk("mr_ins", bus.out_instr, 32'h0);
        chk("mr_err", {31'b0, bus.addr_err}, 32'd0);
        chk("mr_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("mr_c1", {31'b0, bus.out_valid}, 32'd0);
        step();
        head("mr_c2", 32'h0);
        step();
        head("mr_c3", 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
